// File: rtl/cond_flags_unit_pkg.sv
// Shared definitions for the ALU status stage: result-mux op encodings,
// the set of ops that produce a meaningful adder carry/overflow, the ARM
// condition-field encodings and the packed NZCV flag record.
package cond_flags_unit_pkg;

  // Result-mux op select encodings (same codes the ALU result mux uses).
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ORR = 4'b0001;
  localparam logic [3:0] ALU_EOR = 4'b0010;
  localparam logic [3:0] ALU_MOV = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0101;
  localparam logic [3:0] ALU_ADC = 4'b0110;
  localparam logic [3:0] ALU_SC  = 4'b0111;

  // One bit per op code: set where the adder drives the result, so
  // alu_cout/alu_ovf are meaningful. Codes 8..15 are never arithmetic.
  localparam logic [15:0] ARITH_OPS = 16'b0000_0000_1111_0000;

  // ARM condition field encodings.
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Architectural flags, packed so that the vector form is {N,Z,C,V}.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // True when the op select names an adder operation.
  function automatic logic is_arith(input logic [3:0] op);
    return ARITH_OPS[op];
  endfunction

endpackage

// File: rtl/cond_check.sv
// Condition evaluator: decides whether an instruction's ARM condition
// field passes against a set of NZCV flags. Purely combinational.
// Ports:
//   i_cond    [3:0]  condition field
//   i_flags   flags  current {N,Z,C,V}
//   o_cond_ex        1 when the condition passes
module cond_check
  import cond_flags_unit_pkg::*;
(
  input  cond_e  i_cond,
  input  flags_t i_flags,
  output logic   o_cond_ex
);

  logic w_cond_ex;

  // Decode the condition field against the flags.
  always_comb begin
    w_cond_ex = 1'b0;
    case (i_cond)
      COND_EQ: w_cond_ex = i_flags.z;
      COND_NE: w_cond_ex = ~i_flags.z;
      COND_CS: w_cond_ex = i_flags.c;
      COND_CC: w_cond_ex = ~i_flags.c;
      COND_MI: w_cond_ex = i_flags.n;
      COND_PL: w_cond_ex = ~i_flags.n;
      COND_VS: w_cond_ex = i_flags.v;
      COND_VC: w_cond_ex = ~i_flags.v;
      COND_HI: w_cond_ex = i_flags.c & ~i_flags.z;
      COND_LS: w_cond_ex = ~i_flags.c | i_flags.z;
      COND_GE: w_cond_ex = (i_flags.n == i_flags.v);
      COND_LT: w_cond_ex = (i_flags.n != i_flags.v);
      COND_GT: w_cond_ex = ~i_flags.z & (i_flags.n == i_flags.v);
      COND_LE: w_cond_ex = i_flags.z | (i_flags.n != i_flags.v);
      COND_AL: w_cond_ex = 1'b1;
      // NV is reserved and never executes.
      COND_NV: w_cond_ex = 1'b0;
      default: w_cond_ex = 1'b0;
    endcase
  end

  assign o_cond_ex = w_cond_ex;

endmodule

// File: rtl/cond_flags_unit.sv
// ALU status stage: derives NZCV from the selected ALU result and the
// adder side outputs, holds the architectural flag register, evaluates the
// instruction condition against the current flags and gates the datapath
// write enables with the result.
// Ports:
//   clk, reset            rising-edge clock, async active-low reset
//   alu_result [WIDTH]    result mux output
//   alu_cout, alu_ovf     adder carry-out / signed overflow
//   ALUControl [3:0]      op select
//   Cond [3:0]            instruction condition field
//   FlagW [1:0]           [1] update N,Z   [0] update C,V
//   PCS, RegW, MemW       raw write requests
//   PCSrc, RegWrite, MemWrite  requests gated by CondEx
//   CondEx                condition passed on the current flags
//   Flags [3:0]           registered {N,Z,C,V}
//   carry_in              registered C, back to the ALU
module cond_flags_unit
  import cond_flags_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_ovf,
  input  logic [3:0]       ALUControl,
  input  logic [3:0]       Cond,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic             carry_in
);

  flags_t r_flags;
  flags_t w_derived;
  logic   w_cond_ex;

  // Candidate flags from this cycle's result; C and V only move on adder ops.
  always_comb begin
    w_derived.n = alu_result[WIDTH-1];
    w_derived.z = ~(|alu_result);
    if (is_arith(ALUControl)) begin
      w_derived.c = alu_cout;
      w_derived.v = alu_ovf;
    end else begin
      w_derived.c = r_flags.c;
      w_derived.v = r_flags.v;
    end
  end

  // The condition is judged on the registered flags, so a flag-setting
  // instruction never sees its own result.
  cond_check u_cond_check (
    .i_cond    (cond_e'(Cond)),
    .i_flags   (r_flags),
    .o_cond_ex (w_cond_ex)
  );

  // Flag register: the N,Z and C,V halves load independently, and only
  // when the instruction's condition passed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= '0;
    end else begin
      if (FlagW[1] && w_cond_ex) begin
        r_flags.n <= w_derived.n;
        r_flags.z <= w_derived.z;
      end
      if (FlagW[0] && w_cond_ex) begin
        r_flags.c <= w_derived.c;
        r_flags.v <= w_derived.v;
      end
    end
  end

  assign CondEx   = w_cond_ex;
  assign PCSrc    = PCS  & w_cond_ex;
  assign RegWrite = RegW & w_cond_ex;
  assign MemWrite = MemW & w_cond_ex;
  assign Flags    = r_flags;
  assign carry_in = r_flags.c;

endmodule

// File: tb/tb_cond_flags_unit.sv
// Directed bench for cond_flags_unit with hand-computed expectations.
module tb_cond_flags_unit;
  import cond_flags_unit_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;
  logic             alu_ovf;
  logic [3:0]       ALUControl;
  logic [3:0]       Cond;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic [3:0]       Flags;
  logic             carry_in;

  // Standalone evaluator, so flag combinations the datapath cannot
  // produce (N and Z both set) are also exercised.
  logic [3:0] cc_cond;
  logic [3:0] cc_flags;
  logic       cc_ex;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cond_flags_unit #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .alu_ovf    (alu_ovf),
    .ALUControl (ALUControl),
    .Cond       (Cond),
    .FlagW      (FlagW),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
    .PCSrc      (PCSrc),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .CondEx     (CondEx),
    .Flags      (Flags),
    .carry_in   (carry_in)
  );

  cond_check u_cc (
    .i_cond    (cond_e'(cc_cond)),
    .i_flags   (flags_t'(cc_flags)),
    .o_cond_ex (cc_ex)
  );

  // Reference condition table, written from the ARM definitions.
  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction's worth of inputs.
  task automatic drive(input logic [WIDTH-1:0] res, input logic co, input logic ov,
                       input logic [3:0] op, input logic [3:0] cnd, input logic [1:0] fw,
                       input logic pcs_i, input logic regw_i, input logic memw_i);
    alu_result = res; alu_cout = co; alu_ovf = ov; ALUControl = op;
    Cond = cnd; FlagW = fw; PCS = pcs_i; RegW = regw_i; MemW = memw_i;
  endtask

  initial begin
    logic [WIDTH-1:0] res;
    reset = 1'b0;
    drive('0, 1'b0, 1'b0, ALU_AND, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    #3;
    chk("reset_flags", Flags, 4'b0000);
    chk("reset_eq", CondEx, 1'b0);
    Cond = 4'b1110; #1;
    chk("reset_al", CondEx, 1'b1);
    chk("reset_carry_in", carry_in, 1'b0);

    // Load non-zero flags: N=1 Z=0 C=1 V=1.
    @(negedge clk); reset = 1'b1;
    drive(32'h8000_0000, 1'b1, 1'b1, ALU_ADD, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0);
    tick();
    chk("load_1011", Flags, 4'b1011);
    chk("load_carry_in", carry_in, 1'b1);

    // Asynchronous reset mid-cycle clears immediately; X on Cond is harmless.
    #2; reset = 1'b0; #1;
    chk("async_rst_flags", Flags, 4'b0000);
    Cond = 4'b0000; #1;
    chk("async_rst_eq", CondEx, 1'b0);
    Cond = 4'b1110; #1;
    chk("async_rst_al", CondEx, 1'b1);
    Cond = 4'bxxxx;
    tick();
    chk("rst_hold_x_cond", Flags, 4'b0000);

    // Release mid-cycle; SUB with equal operands is captured on the next edge.
    #2; reset = 1'b1;
    drive('0, 1'b1, 1'b0, ALU_SUB, 4'b1110, 2'b11, 1'b1, 1'b1, 1'b1);
    #1;
    chk("al_pcsrc", PCSrc, 1'b1);
    chk("al_regwrite", RegWrite, 1'b1);
    chk("al_memwrite", MemWrite, 1'b1);
    chk("same_cycle_old_flags", Flags, 4'b0000);
    tick();
    chk("sub_eq_flags", Flags, 4'b0110);
    Cond = 4'b0000; #1;
    chk("sub_eq_passes", CondEx, 1'b1);
    Cond = 4'b0001; #1;
    chk("sub_ne_fails", CondEx, 1'b0);
    chk("sub_carry_in", carry_in, 1'b1);

    // Logical op: N,Z from result, C,V held at 1,0.
    drive(32'h8000_0000, 1'b0, 1'b1, ALU_AND, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0);
    tick();
    chk("logic_op_flags", Flags, 4'b1010);

    // EQ with Z=0: nothing executes, flags untouched.
    drive('0, 1'b0, 1'b1, ALU_ADD, 4'b0000, 2'b11, 1'b1, 1'b1, 1'b1);
    #1;
    chk("eq_fail_condex", CondEx, 1'b0);
    chk("eq_fail_pcsrc", PCSrc, 1'b0);
    chk("eq_fail_regwrite", RegWrite, 1'b0);
    chk("eq_fail_memwrite", MemWrite, 1'b0);
    tick();
    chk("eq_fail_flags", Flags, 4'b1010);

    // Split enables: N,Z only, then C,V only, then neither.
    drive('0, 1'b0, 1'b1, ALU_ADD, 4'b1110, 2'b10, 1'b0, 1'b0, 1'b0);
    tick();
    chk("split_nz_only", Flags, 4'b0110);
    drive(32'h8000_0000, 1'b0, 1'b1, ALU_ADD, 4'b1110, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    chk("split_cv_only", Flags, 4'b0101);
    drive(32'h8000_0000, 1'b1, 1'b0, ALU_SC, 4'b1110, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    chk("flagw_00_hold", Flags, 4'b0101);

    // Sweep every reachable flag value through every condition code.
    for (int f = 0; f < 16; f++) begin
      if (f[3] && f[2]) continue;
      res = f[3] ? 32'h8000_0000 : (f[2] ? 32'h0 : 32'h0000_0001);
      drive(res, f[1], f[0], ALU_ADD, 4'b1110, 2'b11, 1'b0, 1'b1, 1'b0);
      tick();
      chk($sformatf("sweep_load_%0d", f), Flags, f[3:0]);
      chk($sformatf("sweep_carry_in_%0d", f), carry_in, f[1]);
      FlagW = 2'b00;
      for (int c = 0; c < 16; c++) begin
        Cond = c[3:0]; #1;
        chk($sformatf("sweep_c%0d_f%0d", c, f), CondEx, cond_ref(c[3:0], f[3:0]));
        chk($sformatf("sweep_rw_c%0d_f%0d", c, f), RegWrite, cond_ref(c[3:0], f[3:0]));
      end
    end

    // Direct evaluator sweep over all 256 combinations.
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        cc_flags = f[3:0]; cc_cond = c[3:0]; #1;
        chk($sformatf("cc_c%0d_f%0d", c, f), cc_ex, cond_ref(c[3:0], f[3:0]));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
